// File: rtl/intirvx_dmem_responder.sv
// intirvx_dmem_responder: data-memory responder for the intirvx core.
// Accepts level-held r_v/w_v requests in IDLE, waits LATENCY cycles, and
// returns a one-cycle dmem_res_v pulse with read data and an error flag,
// servicing the request from an internal word-organised RAM.
module intirvx_dmem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] data_adr,
  input  logic [XLEN-1:0] data_i,
  input  logic [3:0]      strobe,
  output logic [XLEN-1:0] dmem_res,
  output logic            dmem_res_v,
  output logic            dmem_res_error,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            accept;
  logic            enter_resp;

  // Captured request
  logic            req_r_reg, req_w_reg;
  logic [XLEN-1:0] req_adr_reg, req_data_reg;
  logic [3:0]      req_strobe_reg;

  // Request actually being serviced: live ports when LATENCY=1 answers
  // straight out of IDLE, the captured copy otherwise.
  logic            use_ports;
  logic            sel_r, sel_w;
  logic [XLEN-1:0] sel_adr, sel_data;
  logic [3:0]      sel_strobe;
  logic [XLEN-1:0] offset;
  logic [AW-1:0]   idx;
  logic            sel_err;
  logic            do_read, do_write;
  logic [3:0]      lane_we;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign use_ports  = (state_reg == IDLE);
  assign sel_r      = use_ports ? r_v      : req_r_reg;
  assign sel_w      = use_ports ? w_v      : req_w_reg;
  assign sel_adr    = use_ports ? data_adr : req_adr_reg;
  assign sel_data   = use_ports ? data_i   : req_data_reg;
  assign sel_strobe = use_ports ? strobe   : req_strobe_reg;

  // Unsigned subtraction: addresses below the base wrap to huge offsets and
  // fail the range test. Region is a power of two, so the range test is
  // simply "any bit above the region is set".
  assign offset  = sel_adr - BASE_ADDR;
  assign idx     = offset[AW+1:2];
  assign sel_err = (sel_r & sel_w)
                 | (offset[1:0] != 2'b00)
                 | (offset[XLEN-1:AW+2] != '0)
                 | (sel_w & (sel_strobe == 4'b0000));

  assign do_read  = enter_resp & sel_r & ~sel_err;
  assign do_write = enter_resp & sel_w & ~sel_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = do_write & sel_strobe[gi];
    end
  endgenerate

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (r_v | w_v) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counter, request capture and response flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      req_r_reg      <= 1'b0;
      req_w_reg      <= 1'b0;
      req_adr_reg    <= '0;
      req_data_reg   <= '0;
      req_strobe_reg <= 4'b0000;
      dmem_res_v     <= 1'b0;
      dmem_res_error <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dmem_res_v <= enter_resp;
      busy       <= (state_next != IDLE);
      if (accept) begin
        req_r_reg      <= r_v;
        req_w_reg      <= w_v;
        req_adr_reg    <= data_adr;
        req_data_reg   <= data_i;
        req_strobe_reg <= strobe;
      end
      if (enter_resp) begin
        dmem_res_error <= sel_err;
      end
    end
  end

  // Registered RAM read into the response data; zero for writes and errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_res <= '0;
    end else if (enter_resp) begin
      dmem_res <= do_read ? mem[idx] : '0;
    end
  end

  // Byte-lane RAM write; a reset on the response edge suppresses it
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_we[b]) begin
          mem[idx][8*b +: 8] <= sel_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_intirvx_dmem_responder.sv
// Testbench for intirvx_dmem_responder: two instances (LATENCY=1 at base 0,
// LATENCY=4 at base 0x8000_0000) driven through a shared transaction task,
// with a scoreboard of expected responses popped by a response monitor.
module tb_intirvx_dmem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst_n_a  [2];
  logic        r_v_a    [2];
  logic        w_v_a    [2];
  logic [31:0] adr_a    [2];
  logic [31:0] data_a   [2];
  logic [3:0]  stb_a    [2];
  logic [31:0] res_a    [2];
  logic        res_v_a  [2];
  logic        err_a    [2];
  logic        busy_a   [2];

  exp_t sbq0[$];
  exp_t sbq1[$];

  int n_checks = 0;
  int n_errors = 0;

  intirvx_dmem_responder #(
    .XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n_a[0]), .r_v(r_v_a[0]), .w_v(w_v_a[0]),
    .data_adr(adr_a[0]), .data_i(data_a[0]), .strobe(stb_a[0]),
    .dmem_res(res_a[0]), .dmem_res_v(res_v_a[0]),
    .dmem_res_error(err_a[0]), .busy(busy_a[0])
  );

  intirvx_dmem_responder #(
    .XLEN(32), .DEPTH_WORDS(64), .BASE_ADDR(32'h8000_0000), .LATENCY(4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n_a[1]), .r_v(r_v_a[1]), .w_v(w_v_a[1]),
    .data_adr(adr_a[1]), .data_i(data_a[1]), .strobe(stb_a[1]),
    .dmem_res(res_a[1]), .dmem_res_v(res_v_a[1]),
    .dmem_res_error(err_a[1]), .busy(busy_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (res_v_a[0] === 1'b1) begin
      if (sbq0.size() == 0) begin
        chk("u0 unexpected response", 32'd1, 32'd0);
      end else begin
        e = sbq0.pop_front();
        chk({e.tag, " data"}, res_a[0], e.data);
        chk({e.tag, " err"}, {31'd0, err_a[0]}, {31'd0, e.err});
        $display("u0 %s: res=%08h err=%0b", e.tag, res_a[0], err_a[0]);
      end
    end
    if (res_v_a[1] === 1'b1) begin
      if (sbq1.size() == 0) begin
        chk("u1 unexpected response", 32'd1, 32'd0);
      end else begin
        e = sbq1.pop_front();
        chk({e.tag, " data"}, res_a[1], e.data);
        chk({e.tag, " err"}, {31'd0, err_a[1]}, {31'd0, e.err});
        $display("u1 %s: res=%08h err=%0b", e.tag, res_a[1], err_a[1]);
      end
    end
  end

  task automatic push_exp(input int u, input logic [31:0] d, input logic e, input string tag);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.tag  = tag;
    if (u == 0) sbq0.push_back(x);
    else        sbq1.push_back(x);
  endtask

  // One request; called on a falling edge, returns on a falling edge with
  // the interface idle and the pulse checked to have fallen.
  task automatic xact(input int u, input logic r, input logic w,
                      input logic [31:0] adr, input logic [31:0] data,
                      input logic [3:0] stb, input logic [31:0] exp_d,
                      input logic exp_e, input string tag, input bit toggle);
    int  lat;
    int  k;
    bit  seen;
    lat  = (u == 0) ? 1 : 4;
    seen = 1'b0;
    r_v_a[u]  = r;
    w_v_a[u]  = w;
    adr_a[u]  = adr;
    data_a[u] = data;
    stb_a[u]  = stb;
    push_exp(u, exp_d, exp_e, tag);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk({tag, " busy"}, {31'd0, busy_a[u]}, 32'd1);
      if (res_v_a[u] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (toggle) begin
        adr_a[u]  = $urandom;
        data_a[u] = $urandom;
      end
    end
    if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    else       chk({tag, " latency"}, k, lat);
    r_v_a[u] = 1'b0;
    w_v_a[u] = 1'b0;
    @(negedge clk);
    chk({tag, " res_v fall"}, {31'd0, res_v_a[u]}, 32'd0);
    chk({tag, " busy fall"}, {31'd0, busy_a[u]}, 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n_a[u] = 1'b0;
      r_v_a[u]   = 1'b0;
      w_v_a[u]   = 1'b0;
      adr_a[u]   = '0;
      data_a[u]  = '0;
      stb_a[u]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset res_v", u), {31'd0, res_v_a[u]}, 32'd0);
      chk($sformatf("u%0d reset err", u),   {31'd0, err_a[u]},   32'd0);
      chk($sformatf("u%0d reset busy", u),  {31'd0, busy_a[u]},  32'd0);
      chk($sformatf("u%0d reset res", u),   res_a[u],            32'd0);
    end
    rst_n_a[0] = 1'b1;
    rst_n_a[1] = 1'b1;
    @(negedge clk);

    // LATENCY=1, base 0: write then read
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr10", 0);
    xact(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd10", 0);

    // Byte-strobe merge
    xact(0, 0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "wr20 pre", 0);
    xact(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, "wr20 merge", 0);
    xact(0, 1, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "rd20", 0);

    // Error cases; RAM at 0 must survive them
    xact(0, 0, 1, 32'h0, 32'h55AA1234, 4'hF, 32'h0, 1'b0, "wr0 pre", 0);
    xact(0, 1, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, "rd oor", 0);
    xact(0, 1, 0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1, "rd misal", 0);
    xact(0, 1, 1, 32'h0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "rw both", 0);
    xact(0, 0, 1, 32'h0, 32'h77777777, 4'h0, 32'h0, 1'b1, "wr strb0", 0);
    xact(0, 0, 1, 32'h1000, 32'h99999999, 4'hF, 32'h0, 1'b1, "wr oor", 0);
    xact(0, 0, 1, 32'h1, 32'h88888888, 4'hF, 32'h0, 1'b1, "wr misal", 0);
    xact(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h55AA1234, 1'b0, "rd0 after err", 0);

    // Held read with LATENCY=1: pulse every other cycle
    for (int i = 0; i < 4; i++) push_exp(0, 32'h11BB33DD, 1'b0, $sformatf("held%0d", i));
    r_v_a[0] = 1'b1;
    adr_a[0] = 32'h20;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("held pulse c%0d", k), {31'd0, res_v_a[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    r_v_a[0] = 1'b0;
    @(negedge clk);

    // LATENCY=4, base 0x8000_0000, 64 words
    xact(1, 0, 1, 32'h8000_0008, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "l4 wr08", 0);
    xact(1, 1, 0, 32'h8000_0008, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, "l4 rd08 toggle", 1);
    xact(1, 1, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, "l4 below base", 0);
    xact(1, 1, 0, 32'h8000_0100, 32'h0, 4'h0, 32'h0, 1'b1, "l4 above top", 0);

    // Reset mid-WAIT drops a write
    xact(1, 0, 1, 32'h8000_0040, 32'h0, 4'hF, 32'h0, 1'b0, "l4 wr40 pre", 0);
    w_v_a[1]  = 1'b1;
    adr_a[1]  = 32'h8000_0040;
    data_a[1] = 32'hCAFEF00D;
    stb_a[1]  = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n_a[1] = 1'b0;
    w_v_a[1]   = 1'b0;
    repeat (2) @(negedge clk);
    chk("l4 mid reset busy", {31'd0, busy_a[1]}, 32'd0);
    rst_n_a[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("l4 no resp c%0d", k), {31'd0, res_v_a[1]}, 32'd0);
    end
    xact(1, 1, 0, 32'h8000_0040, 32'h0, 4'h0, 32'h0, 1'b0, "l4 rd40 after reset", 0);

    repeat (3) @(negedge clk);
    chk("u0 scoreboard drained", sbq0.size(), 32'd0);
    chk("u1 scoreboard drained", sbq1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
